// File: rtl/interrupt_controller_pkg.sv
// Shared types for the interrupt source block: request vector indices and
// the I/O addresses of the factor-flag and mask nibble registers.
package interrupt_controller_pkg;

  localparam int REQ_WIDTH = 15;

  typedef enum logic [3:0] {
    INT_CLOCK_TIMER = 4'd1,
    INT_STOPWATCH   = 4'd2,
    INT_K0          = 4'd3,
    INT_K1          = 4'd4,
    INT_SERIAL      = 4'd5,
    INT_PROG_TIMER  = 4'd6
  } int_vector;

  // Factor flags (read-clear)
  localparam logic [11:0] ADDR_IT    = 12'hF00;
  localparam logic [11:0] ADDR_ISW   = 12'hF01;
  localparam logic [11:0] ADDR_IPT   = 12'hF02;
  localparam logic [11:0] ADDR_ISIO  = 12'hF03;
  localparam logic [11:0] ADDR_IK0   = 12'hF04;
  localparam logic [11:0] ADDR_IK1   = 12'hF05;

  // Masks (read/write)
  localparam logic [11:0] ADDR_EIT   = 12'hF10;
  localparam logic [11:0] ADDR_EISW  = 12'hF11;
  localparam logic [11:0] ADDR_EIPT  = 12'hF12;
  localparam logic [11:0] ADDR_EISIO = 12'hF13;
  localparam logic [11:0] ADDR_EIK0  = 12'hF14;
  localparam logic [11:0] ADDR_EIK1  = 12'hF15;

endpackage

// File: rtl/interrupt_factor.sv
// One factor-flag register: bits set on event pulses, all bits clear when
// software reads the register, and the masked OR feeds the request logic.
module interrupt_factor
  import interrupt_controller_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] set_pulse,
  input  logic             read_clear,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] flag,
  output logic             req
);

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset that overrides clk_en, so reset lands on the very next clk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= '0;
    end else if (clk_en) begin
      // Set is OR-ed in after the clear so a same-cycle event is never lost.
      flag <= (read_clear ? '0 : flag) | set_pulse;
    end
  end

  assign req = |(flag & mask);

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt source side of the CPU interrupt interface: latches peripheral
// factor flags, holds the mask registers and drives the registered request vector.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        timer_32hz,
  input  logic        timer_8hz,
  input  logic        timer_2hz,
  input  logic        timer_1hz,
  input  logic        sw_10hz,
  input  logic        sw_1hz,
  input  logic        prog_timer_underflow,
  input  logic        serial_done,
  input  logic [3:0]  k0_edge,
  input  logic        k1_edge,
  input  logic [11:0] bus_addr,
  input  logic        bus_read_en,
  input  logic        bus_write_en,
  input  logic [3:0]  bus_write_data,
  output logic [3:0]  bus_read_data,
  output logic [14:0] interrupt_req
);

  logic [3:0] eit;
  logic [1:0] eisw;
  logic       eipt;
  logic       eisio;
  logic [3:0] eik0;
  logic       eik1;

  logic [3:0] it_flag;
  logic [1:0] isw_flag;
  logic       ipt_flag, isio_flag, ik0_flag, ik1_flag;
  logic       it_req, isw_req, ipt_req, isio_req, ik0_req, ik1_req;

  logic             wr_active;
  logic [REQ_WIDTH-1:0] req_next;
  logic [3:0]       read_data;

  // A simultaneous read wins; the write is dropped.
  assign wr_active = bus_write_en && !bus_read_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      eit   <= '0;
      eisw  <= '0;
      eipt  <= 1'b0;
      eisio <= 1'b0;
      eik0  <= '0;
      eik1  <= 1'b0;
    end else if (clk_en && wr_active) begin
      case (bus_addr)
        ADDR_EIT:   eit   <= bus_write_data;
        ADDR_EISW:  eisw  <= bus_write_data[1:0];
        ADDR_EIPT:  eipt  <= bus_write_data[0];
        ADDR_EISIO: eisio <= bus_write_data[0];
        ADDR_EIK0:  eik0  <= bus_write_data;
        ADDR_EIK1:  eik1  <= bus_write_data[0];
        default: ;
      endcase
    end
  end

  interrupt_factor #(.WIDTH(4)) u_it (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  ({timer_1hz, timer_2hz, timer_8hz, timer_32hz}),
    .read_clear (bus_read_en && (bus_addr == ADDR_IT)),
    .mask       (eit),
    .flag       (it_flag),
    .req        (it_req)
  );

  interrupt_factor #(.WIDTH(2)) u_isw (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  ({sw_1hz, sw_10hz}),
    .read_clear (bus_read_en && (bus_addr == ADDR_ISW)),
    .mask       (eisw),
    .flag       (isw_flag),
    .req        (isw_req)
  );

  interrupt_factor #(.WIDTH(1)) u_ipt (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  (prog_timer_underflow),
    .read_clear (bus_read_en && (bus_addr == ADDR_IPT)),
    .mask       (eipt),
    .flag       (ipt_flag),
    .req        (ipt_req)
  );

  interrupt_factor #(.WIDTH(1)) u_isio (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  (serial_done),
    .read_clear (bus_read_en && (bus_addr == ADDR_ISIO)),
    .mask       (eisio),
    .flag       (isio_flag),
    .req        (isio_req)
  );

  // K ports are masked before the flag, so the flag itself is the request.
  interrupt_factor #(.WIDTH(1)) u_ik0 (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  (|(k0_edge & eik0)),
    .read_clear (bus_read_en && (bus_addr == ADDR_IK0)),
    .mask       (1'b1),
    .flag       (ik0_flag),
    .req        (ik0_req)
  );

  interrupt_factor #(.WIDTH(1)) u_ik1 (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .set_pulse  (k1_edge && eik1),
    .read_clear (bus_read_en && (bus_addr == ADDR_IK1)),
    .mask       (1'b1),
    .flag       (ik1_flag),
    .req        (ik1_req)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    read_data = '0;
    if (bus_read_en) begin
      case (bus_addr)
        ADDR_IT:    read_data = it_flag;
        ADDR_ISW:   read_data = {2'b00, isw_flag};
        ADDR_IPT:   read_data = {3'b000, ipt_flag};
        ADDR_ISIO:  read_data = {3'b000, isio_flag};
        ADDR_IK0:   read_data = {3'b000, ik0_flag};
        ADDR_IK1:   read_data = {3'b000, ik1_flag};
        ADDR_EIT:   read_data = eit;
        ADDR_EISW:  read_data = {2'b00, eisw};
        ADDR_EIPT:  read_data = {3'b000, eipt};
        ADDR_EISIO: read_data = {3'b000, eisio};
        ADDR_EIK0:  read_data = eik0;
        ADDR_EIK1:  read_data = {3'b000, eik1};
        default:    read_data = '0;
      endcase
    end
  end

  assign bus_read_data = read_data;

  always_comb begin
    req_next                  = '0;
    req_next[INT_CLOCK_TIMER] = it_req;
    req_next[INT_STOPWATCH]   = isw_req;
    req_next[INT_K0]          = ik0_req;
    req_next[INT_K1]          = ik1_req;
    req_next[INT_SERIAL]      = isio_req;
    req_next[INT_PROG_TIMER]  = ipt_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_req <= '0;
    end else if (clk_en) begin
      interrupt_req <= req_next;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed register reads and
// request-vector values around flag set, read-clear, masking and reset.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        timer_32hz, timer_8hz, timer_2hz, timer_1hz;
  logic        sw_10hz, sw_1hz;
  logic        prog_timer_underflow;
  logic        serial_done;
  logic [3:0]  k0_edge;
  logic        k1_edge;
  logic [11:0] bus_addr;
  logic        bus_read_en;
  logic        bus_write_en;
  logic [3:0]  bus_write_data;
  logic [3:0]  bus_read_data;
  logic [14:0] interrupt_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .clk_en               (clk_en),
    .timer_32hz           (timer_32hz),
    .timer_8hz            (timer_8hz),
    .timer_2hz            (timer_2hz),
    .timer_1hz            (timer_1hz),
    .sw_10hz              (sw_10hz),
    .sw_1hz               (sw_1hz),
    .prog_timer_underflow (prog_timer_underflow),
    .serial_done          (serial_done),
    .k0_edge              (k0_edge),
    .k1_edge              (k1_edge),
    .bus_addr             (bus_addr),
    .bus_read_en          (bus_read_en),
    .bus_write_en         (bus_write_en),
    .bus_write_data       (bus_write_data),
    .bus_read_data        (bus_read_data),
    .interrupt_req        (interrupt_req)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [11:0] a, input logic [3:0] d);
    bus_addr       = a;
    bus_write_data = d;
    bus_write_en   = 1'b1;
    tick();
    bus_write_en   = 1'b0;
  endtask

  task automatic read_reg(input logic [11:0] a, output logic [3:0] d);
    bus_addr    = a;
    bus_read_en = 1'b1;
    #1 d = bus_read_data;
    tick();
    bus_read_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rd;
    logic [11:0] all_addr [12];
    all_addr = '{12'hF00, 12'hF01, 12'hF02, 12'hF03, 12'hF04, 12'hF05,
                 12'hF10, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15};

    reset = 1'b1; clk_en = 1'b1;
    timer_32hz = 0; timer_8hz = 0; timer_2hz = 0; timer_1hz = 0;
    sw_10hz = 0; sw_1hz = 0; prog_timer_underflow = 0; serial_done = 0;
    k0_edge = '0; k1_edge = 0;
    bus_addr = '0; bus_read_en = 0; bus_write_en = 0; bus_write_data = '0;
    tick(); tick();
    reset = 1'b0;

    check("reset_req", {1'b0, interrupt_req}, 16'h0000);
    read_reg(12'hF10, rd); check("reset_eit", {12'h0, rd}, 16'h0);

    // Clock timer: 2-edge latency, read-clear drops request one edge later.
    write_reg(12'hF10, 4'h1);
    read_reg(12'hF10, rd); check("eit_rb", {12'h0, rd}, 16'h1);
    timer_32hz = 1'b1; tick(); timer_32hz = 1'b0;
    check("it_req_edge1", {1'b0, interrupt_req}, 16'h0000);
    tick();
    check("it_req_edge2", {1'b0, interrupt_req}, 16'h0002);
    read_reg(12'hF00, rd); check("it_read1", {12'h0, rd}, 16'h1);
    check("it_req_after_read", {1'b0, interrupt_req}, 16'h0002);
    read_reg(12'hF00, rd); check("it_read2", {12'h0, rd}, 16'h0);
    check("it_req_cleared", {1'b0, interrupt_req}, 16'h0000);

    // Programmable timer: flag latches while masked, mask write raises req.
    prog_timer_underflow = 1'b1; tick(); prog_timer_underflow = 1'b0;
    tick(); tick();
    check("ipt_masked_req", {1'b0, interrupt_req}, 16'h0000);
    write_reg(12'hF12, 4'h1);
    tick();
    check("ipt_unmasked_req", {1'b0, interrupt_req}, 16'h0040);
    read_reg(12'hF02, rd); check("ipt_read", {12'h0, rd}, 16'h1);
    tick();
    check("ipt_req_cleared", {1'b0, interrupt_req}, 16'h0000);

    // K0: edges gated by mask before the flag.
    write_reg(12'hF14, 4'h4);
    k0_edge = 4'h1; tick(); k0_edge = 4'h0;
    tick(); tick();
    check("ik0_blocked_req", {1'b0, interrupt_req}, 16'h0000);
    read_reg(12'hF04, rd); check("ik0_blocked", {12'h0, rd}, 16'h0);
    k0_edge = 4'h4; tick(); k0_edge = 4'h0;
    tick();
    check("ik0_req", {1'b0, interrupt_req}, 16'h0008);
    read_reg(12'hF04, rd); check("ik0_set", {12'h0, rd}, 16'h1);
    tick();
    check("ik0_req_cleared", {1'b0, interrupt_req}, 16'h0000);

    // Write to a flag register is ignored; mask write drops unused bits.
    write_reg(12'hF00, 4'hF);
    read_reg(12'hF00, rd); check("it_write_ignored", {12'h0, rd}, 16'h0);
    write_reg(12'hF11, 4'hF);
    read_reg(12'hF11, rd); check("eisw_width", {12'h0, rd}, 16'h3);

    // Stopwatch: event during the read cycle survives the clear.
    bus_addr = 12'hF01; bus_read_en = 1'b1; sw_1hz = 1'b1;
    #1 rd = bus_read_data;
    tick();
    bus_read_en = 1'b0; sw_1hz = 1'b0;
    check("isw_read_pre_event", {12'h0, rd}, 16'h0);
    tick();
    check("isw_req", {1'b0, interrupt_req}, 16'h0004);
    read_reg(12'hF01, rd); check("isw_kept", {12'h0, rd}, 16'h2);
    tick();
    check("isw_req_cleared", {1'b0, interrupt_req}, 16'h0000);

    // Simultaneous read and write: read honoured, write dropped.
    bus_addr = 12'hF14; bus_read_en = 1'b1; bus_write_en = 1'b1; bus_write_data = 4'hF;
    #1 rd = bus_read_data;
    tick();
    bus_read_en = 1'b0; bus_write_en = 1'b0;
    check("rw_read_value", {12'h0, rd}, 16'h4);
    read_reg(12'hF14, rd); check("rw_write_dropped", {12'h0, rd}, 16'h4);

    // Unmapped address reads zero.
    read_reg(12'hF06, rd); check("unmapped", {12'h0, rd}, 16'h0);

    // clk_en low: pulses are not captured and reads do not clear.
    clk_en = 1'b0; timer_1hz = 1'b1; tick(); timer_1hz = 1'b0; clk_en = 1'b1;
    read_reg(12'hF00, rd); check("clk_en_low_pulse", {12'h0, rd}, 16'h0);
    timer_8hz = 1'b1; tick(); timer_8hz = 1'b0;
    clk_en = 1'b0;
    read_reg(12'hF00, rd); check("clk_en_low_read", {12'h0, rd}, 16'h2);
    clk_en = 1'b1;
    read_reg(12'hF00, rd); check("clk_en_high_read", {12'h0, rd}, 16'h2);
    read_reg(12'hF00, rd); check("it_cleared_again", {12'h0, rd}, 16'h0);

    // All sources active, then a one-cycle reset with clk_en low.
    write_reg(12'hF10, 4'hF);
    write_reg(12'hF11, 4'h3);
    write_reg(12'hF12, 4'h1);
    write_reg(12'hF13, 4'h1);
    write_reg(12'hF14, 4'hF);
    write_reg(12'hF15, 4'h1);
    timer_32hz = 1'b1; sw_10hz = 1'b1; prog_timer_underflow = 1'b1;
    serial_done = 1'b1; k0_edge = 4'h1; k1_edge = 1'b1;
    tick();
    timer_32hz = 1'b0; sw_10hz = 1'b0; prog_timer_underflow = 1'b0;
    serial_done = 1'b0; k0_edge = 4'h0; k1_edge = 1'b0;
    tick();
    check("all_req", {1'b0, interrupt_req}, 16'h007E);
    clk_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0; clk_en = 1'b1;
    check("mid_reset_req", {1'b0, interrupt_req}, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      read_reg(all_addr[i], rd);
      check($sformatf("mid_reset_%h", all_addr[i]), {12'h0, rd}, 16'h0);
    end
    check("final_req", {1'b0, interrupt_req}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source side of the CPU core's interrupt interface. Latches interrupt factor flags from the peripherals (clock timer, stopwatch, K0/K1 input ports, serial, programmable timer) and holds the I/O-mapped factor-flag and mask registers. Flags clear when software reads them. Produces the 15-bit `interrupt_req` vector that the microcode sequencer priority-encodes, where the highest set index wins.

## Interface
Parameters: none.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  CPU clock enable; all state updates only on clk_en
- timer_32hz, timer_8hz, timer_2hz, timer_1hz  in  1 each  single-clk_en-cycle event pulses from clock timer
- sw_10hz, sw_1hz  in  1 each  stopwatch event pulses
- prog_timer_underflow  in  1  programmable timer event pulse
- serial_done  in  1  serial transfer complete pulse
- k0_edge  in  4  qualified edge pulses, K00–K03
- k1_edge  in  1  qualified edge pulse, K10
- bus_addr  in  12  CPU data bus address
- bus_read_en  in  1  CPU read strobe
- bus_write_en  in  1  CPU write strobe
- bus_write_data  in  4  write nibble
- bus_read_data  out  4  read nibble; 0 when the address is not owned
- interrupt_req  out  15  per-vector request level to the microcode sequencer

## Operation
- Register map (nibble registers; F = read-clear, RW = read/write):
  - 0xF00 IT (F): {1Hz, 2Hz, 8Hz, 32Hz} in bits [3:0]
  - 0xF01 ISW (F): {0, 0, 1Hz, 10Hz}
  - 0xF02 IPT (F): bit 0
  - 0xF03 ISIO (F): bit 0
  - 0xF04 IK0 (F): bit 0
  - 0xF05 IK1 (F): bit 0
  - 0xF10 EIT (RW): same layout as IT
  - 0xF11 EISW (RW): bits [1:0]
  - 0xF12 EIPT (RW): bit 0
  - 0xF13 EISIO (RW): bit 0
  - 0xF14 EIK0 (RW): bits [3:0]
  - 0xF15 EIK1 (RW): bit 0
- Flag setting:
  - IT/ISW/IPT/ISIO flags set on their event pulse regardless of mask.
  - IK0 sets only when |(k0_edge & EIK0).
  - IK1 sets only when k1_edge & EIK1.
- Read: bus_read_data is combinational from the current register value. All bits of an F register clear at the clk_en edge of the read cycle.
- Write: RW registers load bus_write_data, unused bits forced 0. Writes to F registers and unmapped addresses are ignored. Writing a mask never alters flags.
- Read and write strobes together at one address: the write is ignored, the read is honoured.
- Request vector (registered):
  - req[1] = |(IT & EIT)
  - req[2] = |(ISW & EISW)
  - req[3] = IK0
  - req[4] = IK1
  - req[5] = ISIO & EISIO
  - req[6] = IPT & EIPT
  - all other bits 0
- No acknowledge input. A request stays asserted until software reads the flag or clears the mask. Re-entry prevention belongs to the sequencer.

## Timing
- Reset: all flags, masks and interrupt_req are 0; bus_read_data is 0.
- Event pulse in clk_en cycle N: flag set at the edge ending N. interrupt_req updates at the edge ending N+1, so latency is 2 clk_en edges.
- Event and read of the same flag in the same clk_en cycle:
  - read returns the pre-event value;
  - the flag ends set (set wins over clear), so the event is not lost.
- Read-clear in cycle N: the request drops at the edge ending N+1.
- Mask write in cycle N: takes effect on interrupt_req at the edge ending N+1.
- clk_en low: no state changes; pulses presented while clk_en is low are not captured.
- Reset mid-operation: all state is cleared on the next clk edge, independent of clk_en.

## Structure
- Shared types package:
  - enum int_vector: INT_CLOCK_TIMER=1, INT_STOPWATCH=2, INT_K0=3, INT_K1=4, INT_SERIAL=5, INT_PROG_TIMER=6
  - localparam addresses for all twelve registers
- One sub-module, `interrupt_factor`:
  - parameter WIDTH
  - inputs: set pulses, read-clear, mask
  - outputs: flag value, masked-OR request
  - instantiated for IT, ISW, IPT, ISIO, IK0, IK1; IK0/IK1 use an all-ones mask and are gated on input
- The top level holds the mask registers, the address decode/read mux and the interrupt_req register.

## Test plan
- Reset, then EIT=0x1, pulse timer_32hz → IT reads 0x1, req[1]=1 two edges after the pulse; a second read returns 0x0 and req[1]=0.
- EIPT=0, pulse prog_timer_underflow → IPT=1, req[6]=0; write EIPT=1 → req[6]=1 next edge.
- EIK0=0x4, pulse k0_edge=0x1 → IK0 stays 0; pulse k0_edge=0x4 → IK0=1, req[3]=1.
- Read ISW while sw_1hz pulses in the same cycle → read data 0x0, ISW=0x2 afterwards.
- Write 0xF to 0xF00 → IT unchanged; write 0xF to 0xF11 → EISW reads 0x3.
- Set all six sources with masks 1, assert reset for one cycle → every register reads 0 and interrupt_req=0.
